// File: rtl/ir_sram_row_loader.sv
// Streams one input feature map tile into two IR SRAM banks: even image rows to bank 1, odd rows to bank 2.
// Stream order: rows 0/1 interleaved per column, then rows 2..ROW-1 in snake order.
module ir_sram_row_loader #(
    parameter int CHANNEL_OUT = 32,
    parameter int SRAM_NUM    = 16,
    parameter int ROW         = 6,
    parameter int COL         = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CHANNEL_OUT*8-1:0]   data_in_1,
    output logic                       CEN1_ir,
    output logic [SRAM_NUM-1:0]        WEN1_ir,
    output logic [6:0]                 A1_ir,
    output logic [SRAM_NUM*16-1:0]     D1_ir,
    output logic                       CEN2_ir,
    output logic [SRAM_NUM-1:0]        WEN2_ir,
    output logic [6:0]                 A2_ir,
    output logic [SRAM_NUM*16-1:0]     D2_ir,
    output logic                       done
);

    localparam int RW = $clog2(ROW + 1);
    localparam int CW = $clog2(COL + 1);
    localparam int DW = SRAM_NUM * 16;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        LOAD,
        DONE
    } state_t;

    state_t          state_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic            snake_q;
    logic [6:0]      base_q;
    logic            done_q;

    logic [CW-1:0]   col_eff;
    logic [6:0]      addr;

    // In the snake phase col_q counts stream position within the row; even rows run right-to-left.
    always_comb begin
        if (snake_q && !row_q[0]) begin
            col_eff = CW'(COL - 1) - col_q;
        end else begin
            col_eff = col_q;
        end
        addr = base_q + 7'(col_eff);
    end

    always_comb begin
        CEN1_ir = 1'b1;
        WEN1_ir = '1;
        A1_ir   = '0;
        D1_ir   = '0;
        CEN2_ir = 1'b1;
        WEN2_ir = '1;
        A2_ir   = '0;
        D2_ir   = '0;
        if (state_q == LOAD) begin
            if (!row_q[0]) begin
                CEN1_ir = 1'b0;
                WEN1_ir = '0;
                A1_ir   = addr;
                D1_ir   = DW'(data_in_1);
            end else begin
                CEN2_ir = 1'b0;
                WEN2_ir = '0;
                A2_ir   = addr;
                D2_ir   = DW'(data_in_1);
            end
        end
    end

    assign done = done_q;

    // base_q tracks (row/2)*COL incrementally so no multiplier or divider is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            snake_q <= 1'b0;
            base_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    row_q   <= '0;
                    col_q   <= '0;
                    snake_q <= 1'b0;
                    base_q  <= '0;
                    state_q <= LOAD;
                end
                LOAD: begin
                    if (!snake_q) begin
                        if (!row_q[0]) begin
                            row_q <= RW'(1);
                        end else if (col_q != CW'(COL - 1)) begin
                            row_q <= '0;
                            col_q <= col_q + 1'b1;
                        end else if (ROW == 2) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            snake_q <= 1'b1;
                            row_q   <= RW'(2);
                            col_q   <= '0;
                            base_q  <= 7'(COL);
                        end
                    end else if (col_q != CW'(COL - 1)) begin
                        col_q <= col_q + 1'b1;
                    end else if (row_q == RW'(ROW - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                        if (row_q[0]) begin
                            base_q <= base_q + 7'(COL);
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_sram_row_loader.sv
// Randomized self-checking bench for ir_sram_row_loader with a behavioural pixel-to-SRAM reference model.
module tb_ir_sram_row_loader;

    localparam int CH  = 32;
    localparam int SN  = 16;
    localparam int ROW = 6;
    localparam int COL = 6;
    localparam int N   = ROW * COL;
    localparam int DW  = SN * 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [CH*8-1:0] data_in_1;
    logic           CEN1_ir, CEN2_ir;
    logic [SN-1:0]  WEN1_ir, WEN2_ir;
    logic [6:0]     A1_ir, A2_ir;
    logic [DW-1:0]  D1_ir, D2_ir;
    logic           done;

    logic [DW-1:0]  pix [ROW][COL];
    logic [DW-1:0]  mem1 [128];
    logic [DW-1:0]  mem2 [128];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ir_sram_row_loader #(
        .CHANNEL_OUT(CH),
        .SRAM_NUM   (SN),
        .ROW        (ROW),
        .COL        (COL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in_1(data_in_1),
        .CEN1_ir  (CEN1_ir),
        .WEN1_ir  (WEN1_ir),
        .A1_ir    (A1_ir),
        .D1_ir    (D1_ir),
        .CEN2_ir  (CEN2_ir),
        .WEN2_ir  (WEN2_ir),
        .A2_ir    (A2_ir),
        .D2_ir    (D2_ir),
        .done     (done)
    );

    // Connected IR SRAMs: per-lane write when CEN low and the lane's WEN bit low.
    always @(posedge clk) begin
        if (CEN1_ir === 1'b0) begin
            for (int l = 0; l < SN; l++) begin
                if (WEN1_ir[l] === 1'b0) mem1[A1_ir][l*16 +: 16] <= D1_ir[l*16 +: 16];
            end
        end
        if (CEN2_ir === 1'b0) begin
            for (int l = 0; l < SN; l++) begin
                if (WEN2_ir[l] === 1'b0) mem2[A2_ir][l*16 +: 16] <= D2_ir[l*16 +: 16];
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void pixel_pos(input int k, output int r, output int c);
        int j;
        int idx;
        if (k < 2 * COL) begin
            r = k % 2;
            c = k / 2;
        end else begin
            j   = k - 2 * COL;
            r   = 2 + j / COL;
            idx = j % COL;
            c   = (r % 2 == 0) ? (COL - 1 - idx) : idx;
        end
    endfunction

    task automatic new_pixels();
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COL; c++) begin
                pix[r][c] = '0;
                pix[r][c][31:0] = $urandom();
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " CEN1"}, DW'(CEN1_ir), DW'(1));
        check({tag, " CEN2"}, DW'(CEN2_ir), DW'(1));
        check({tag, " WEN1"}, DW'(WEN1_ir), DW'({SN{1'b1}}));
        check({tag, " WEN2"}, DW'(WEN2_ir), DW'({SN{1'b1}}));
        check({tag, " A1"}, DW'(A1_ir), '0);
        check({tag, " A2"}, DW'(A2_ir), '0);
        check({tag, " D1"}, D1_ir, '0);
        check({tag, " D2"}, D2_ir, '0);
    endtask

    task automatic run_load(input int abort_k, input bit rand_start);
        int r;
        int c;
        int a;
        string t;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (rand_start) start = ($urandom_range(0, 1) == 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            pixel_pos(k, r, c);
            a = (r / 2) * COL + c;
            data_in_1 = pix[r][c];
            if (rand_start) start = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            t = $sformatf("k=%0d", k);
            if (r % 2 == 0) begin
                check({t, " CEN1"}, DW'(CEN1_ir), DW'(0));
                check({t, " WEN1"}, DW'(WEN1_ir), '0);
                check({t, " A1"}, DW'(A1_ir), DW'(a));
                check({t, " D1"}, D1_ir, pix[r][c]);
                check({t, " CEN2"}, DW'(CEN2_ir), DW'(1));
                check({t, " WEN2"}, DW'(WEN2_ir), DW'({SN{1'b1}}));
                check({t, " A2"}, DW'(A2_ir), '0);
                check({t, " D2"}, D2_ir, '0);
            end else begin
                check({t, " CEN2"}, DW'(CEN2_ir), DW'(0));
                check({t, " WEN2"}, DW'(WEN2_ir), '0);
                check({t, " A2"}, DW'(A2_ir), DW'(a));
                check({t, " D2"}, D2_ir, pix[r][c]);
                check({t, " CEN1"}, DW'(CEN1_ir), DW'(1));
                check({t, " WEN1"}, DW'(WEN1_ir), DW'({SN{1'b1}}));
                check({t, " A1"}, DW'(A1_ir), '0);
                check({t, " D1"}, D1_ir, '0);
            end
            check({t, " done"}, DW'(done), DW'(0));
            if (k == abort_k) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_idle("async_rst");
                check("async_rst done", DW'(done), DW'(0));
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        @(negedge clk);
        check("done_rise", DW'(done), DW'(1));
        check_idle("done_state");
        @(posedge clk);
        #1;
        @(negedge clk);
        check("done_held", DW'(done), DW'(1));
        start = 1'b0;
        @(posedge clk);
        #1;
        check("done_drop", DW'(done), DW'(0));
        @(negedge clk);
        check_idle("idle_after");
    endtask

    task automatic readback(input string tag);
        int a;
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COL; c++) begin
                a = (r / 2) * COL + c;
                if (r % 2 == 0) check($sformatf("%s b1 r%0d c%0d", tag, r, c), mem1[a], pix[r][c]);
                else            check($sformatf("%s b2 r%0d c%0d", tag, r, c), mem2[a], pix[r][c]);
            end
        end
        check({tag, " b1w15"}, mem1[15], pix[4][3]);
        check({tag, " b2w7"}, mem2[7], pix[3][1]);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        data_in_1 = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("reset");
        check("reset done", DW'(done), DW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        new_pixels();
        run_load(20, 1'b1);
        @(posedge clk);
        #1;

        new_pixels();
        run_load(-1, 1'b1);
        @(posedge clk);
        #1;
        readback("load1");

        new_pixels();
        run_load(-1, 1'b0);
        @(posedge clk);
        #1;
        readback("load2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
